bit_set_sequencer: RTL

- Shared WIDTH-bit status register updated one bit at a time: y[index] <= value, all other bits held.
- Arbitrates between two requesters using round-robin priority.
- Also contains a fill sequencer that walks every bit position and writes a common value.
- Sits between control agents and the bit-set datapath; owns and sequences all writes to the register.

---
 rtl/bit_set_sequencer_if.sv | 32 +++
 rtl/bit_set_sequencer.sv | 123 ++++++++++++
 2 files changed

// File: rtl/bit_set_sequencer_if.sv
// Bundles every non-clock, non-reset signal of bit_set_sequencer.
//   master : control side. Drives the two requesters (req/idx/val) and the fill
//            controls (fill_start/fill_val). Observes gnt0/gnt1/busy/done/y.
//   slave  : the sequencer itself, which owns the status register.
interface bit_set_sequencer_if #(
   parameter int WIDTH = 4,
   parameter int IDXW  = 2
);
   logic             req0;
   logic [IDXW-1:0]  idx0;
   logic             val0;
   logic             req1;
   logic [IDXW-1:0]  idx1;
   logic             val1;
   logic             fill_start;
   logic             fill_val;
   logic             gnt0;
   logic             gnt1;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] y;

   modport master (
      output req0, idx0, val0, req1, idx1, val1, fill_start, fill_val,
      input  gnt0, gnt1, busy, done, y
   );

   modport slave (
      input  req0, idx0, val0, req1, idx1, val1, fill_start, fill_val,
      output gnt0, gnt1, busy, done, y
   );
endinterface

// File: rtl/bit_set_sequencer.sv
// Owns a WIDTH-bit status register. Each write changes exactly one bit.
// Two requesters are served round-robin. A fill sequence can also walk
// every bit and write one common value to all of them.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : bit_set_sequencer_if.slave
//           inputs  req0/idx0/val0, req1/idx1/val1, fill_start, fill_val
//           outputs gnt0, gnt1 (one-cycle grant pulses), busy (fill active),
//                   done (one-cycle fill-complete pulse), y (register)
// All outputs are registered.
//
// state | meaning
// IDLE  | arbitrate requests; fill_start takes precedence over requests
// FILL  | write latched fill value to y[cnt], cnt = 0 .. WIDTH-1
module bit_set_sequencer #(
   parameter int WIDTH = 4,
   parameter int IDXW  = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   bit_set_sequencer_if.slave   bus
);
   typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [IDXW-1:0]  cnt_q, cnt_d;
   logic             fval_q, fval_d;
   logic             ptr_q, ptr_d;     // 0: requester 0 wins a tie
   logic             gnt0_q, gnt0_d;
   logic             gnt1_q, gnt1_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             win1;
   logic [IDXW-1:0]  idx_w;
   logic             val_w;

   assign win1  = bus.req1 & (~bus.req0 | ptr_q);
   assign idx_w = win1 ? bus.idx1 : bus.idx0;
   assign val_w = win1 ? bus.val1 : bus.val0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         y_q     <= '0;
         cnt_q   <= '0;
         fval_q  <= 1'b0;
         ptr_q   <= 1'b0;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         cnt_q   <= cnt_d;
         fval_q  <= fval_d;
         ptr_q   <= ptr_d;
         gnt0_q  <= gnt0_d;
         gnt1_q  <= gnt1_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.fill_start) state_d = FILL;
         FILL:    if (cnt_q == LAST_IDX) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      y_d    = y_q;
      cnt_d  = cnt_q;
      fval_d = fval_q;
      ptr_d  = ptr_q;
      gnt0_d = 1'b0;
      gnt1_d = 1'b0;
      busy_d = 1'b0;
      done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.fill_start) begin
               fval_d = bus.fill_val;
               cnt_d  = '0;
               busy_d = 1'b1;
            end else if (bus.req0 | bus.req1) begin
               // An out-of-range index is still granted, but leaves y untouched.
               if (int'(idx_w) < WIDTH) y_d[idx_w] = val_w;
               gnt0_d = ~win1;
               gnt1_d = win1;
               ptr_d  = ~win1;
            end
         end
         FILL: begin
            y_d[cnt_q] = fval_q;
            // The end is detected by compare rather than by wrap, so a
            // non-power-of-2 WIDTH still stops at WIDTH-1.
            if (cnt_q == LAST_IDX) begin
               cnt_d  = '0;
               done_d = 1'b1;
            end else begin
               cnt_d  = cnt_q + IDXW'(1);
               busy_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign bus.y    = y_q;
   assign bus.gnt0 = gnt0_q;
   assign bus.gnt1 = gnt1_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
endmodule
